// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: prescaled calendar clock with Gregorian leap years,
// field set/step port and hour:minute alarms with timed active flags.
module rtc_calendar_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ALARM_NUM  = 2,
  parameter int ALARM_SECS = 60,
  parameter int RST_YEAR   = 2019
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 set_valid,
  input  logic                 step_up,
  input  logic                 step_down,
  input  logic [2:0]           set_field,
  input  logic [13:0]          set_data,
  output logic                 set_err,
  input  logic                 alarm_wr,
  input  logic [2:0]           alarm_idx,
  input  logic [4:0]           alarm_hour,
  input  logic [5:0]           alarm_min,
  input  logic                 alarm_en_in,
  input  logic [ALARM_NUM-1:0] alarm_ack,
  output logic [5:0]           sec,
  output logic [5:0]           min,
  output logic [4:0]           hour,
  output logic [4:0]           day,
  output logic [3:0]           month,
  output logic [13:0]          year,
  output logic [2:0]           week,
  output logic                 sec_tick,
  output logic                 chime,
  output logic [ALARM_NUM-1:0] alarm_hit,
  output logic [ALARM_NUM-1:0] alarm_active
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    F_SEC, F_MIN, F_HOUR, F_DAY,
    F_MONTH, F_YEAR, F_WEEK, F_BAD
  } field_e;

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0))
        || ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] dim(
    input logic [3:0]  m,
    input logic [13:0] y
  );
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:    dim = is_leap(y) ? 5'd29 : 5'd28;
      default: dim = 5'd31;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d;
  logic [3:0]    month_q, month_d;
  logic [13:0]   year_q, year_d;
  logic [2:0]    week_q, week_d;
  logic          tick_q, tick_d, chime_q, chime_d, err_q, err_d;

  logic [4:0] al_hour_q [ALARM_NUM];
  logic [4:0] al_hour_d [ALARM_NUM];
  logic [5:0] al_min_q  [ALARM_NUM];
  logic [5:0] al_min_d  [ALARM_NUM];
  logic [7:0] cnt_q     [ALARM_NUM];
  logic [7:0] cnt_d     [ALARM_NUM];
  logic [ALARM_NUM-1:0] al_en_q, al_en_d;
  logic [ALARM_NUM-1:0] act_q, act_d;
  logic [ALARM_NUM-1:0] hit_q, hit_d;

  logic       adv, acc, clamp;
  logic [4:0] lim, cur_dim;

  // Calendar next state: set/step writes win over the second advance
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    week_d  = week_q;
    tick_d  = 1'b0;
    chime_d = 1'b0;
    err_d   = 1'b0;
    acc     = 1'b0;
    clamp   = 1'b0;
    lim     = 5'd31;
    cur_dim = dim(month_q, year_q);
    adv     = run && (presc_q == PMAX);
    if (!run || adv) presc_d = '0;
    else             presc_d = presc_q + 1'b1;

    if (set_valid) begin
      acc = 1'b1;
      case (field_e'(set_field))
        F_SEC:
          if (set_data <= 14'd59) sec_d = set_data[5:0];
          else acc = 1'b0;
        F_MIN:
          if (set_data <= 14'd59) min_d = set_data[5:0];
          else acc = 1'b0;
        F_HOUR:
          if (set_data <= 14'd23) hour_d = set_data[4:0];
          else acc = 1'b0;
        F_DAY:
          if (set_data >= 14'd1 && set_data <= {9'd0, cur_dim})
            day_d = set_data[4:0];
          else acc = 1'b0;
        F_MONTH:
          if (set_data >= 14'd1 && set_data <= 14'd12) begin
            month_d = set_data[3:0];
            clamp   = 1'b1;
          end else acc = 1'b0;
        F_YEAR:
          if (set_data <= 14'd9999) begin
            year_d = set_data;
            clamp  = 1'b1;
          end else acc = 1'b0;
        F_WEEK:
          if (set_data <= 14'd6) week_d = set_data[2:0];
          else acc = 1'b0;
        default: acc = 1'b0;
      endcase
      err_d = !acc;
    end else if (step_up || step_down) begin
      acc = 1'b1;
      case (field_e'(set_field))
        F_SEC:
          if (step_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          else         sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        F_MIN:
          if (step_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else         min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        F_HOUR:
          if (step_up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          else         hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        F_DAY:
          if (step_up) day_d = (day_q >= cur_dim) ? 5'd1 : day_q + 5'd1;
          else         day_d = (day_q <= 5'd1) ? cur_dim : day_q - 5'd1;
        F_MONTH: begin
          clamp = 1'b1;
          if (step_up) month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
          else         month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
        end
        F_YEAR: begin
          clamp = 1'b1;
          if (step_up)
            year_d = (year_q >= 14'd9999) ? 14'd0 : year_q + 14'd1;
          else
            year_d = (year_q == 14'd0) ? 14'd9999 : year_q - 14'd1;
        end
        F_WEEK:
          if (step_up) week_d = (week_q >= 3'd6) ? 3'd0 : week_q + 3'd1;
          else         week_d = (week_q == 3'd0) ? 3'd6 : week_q - 3'd1;
        default: acc = 1'b0;
      endcase
      err_d = !acc;
    end

    if (clamp) begin
      lim = dim(month_d, year_d);
      if (day_q > lim) day_d = lim;
    end

    if (acc) begin
      presc_d = '0;
    end else if (adv) begin
      tick_d = 1'b1;
      if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
      else begin
        sec_d = 6'd0;
        if (min_q != 6'd59) min_d = min_q + 6'd1;
        else begin
          min_d   = 6'd0;
          chime_d = 1'b1;
          if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
          else begin
            hour_d = 5'd0;
            week_d = (week_q >= 3'd6) ? 3'd0 : week_q + 3'd1;
            if (day_q < cur_dim) day_d = day_q + 5'd1;
            else begin
              day_d = 5'd1;
              if (month_q != 4'd12) month_d = month_q + 4'd1;
              else begin
                month_d = 4'd1;
                year_d  = (year_q >= 14'd9999) ? 14'd0 : year_q + 14'd1;
              end
            end
          end
        end
      end
    end
  end

  // Alarm config, match detection and ringing timers
  always_comb begin
    for (int i = 0; i < ALARM_NUM; i++) begin
      al_hour_d[i] = al_hour_q[i];
      al_min_d[i]  = al_min_q[i];
      al_en_d[i]   = al_en_q[i];
      cnt_d[i]     = cnt_q[i];
      act_d[i]     = act_q[i];
      hit_d[i]     = 1'b0;
      if (alarm_wr && alarm_idx == 3'(i)) begin
        al_hour_d[i] = alarm_hour;
        al_min_d[i]  = alarm_min;
        al_en_d[i]   = alarm_en_in;
        act_d[i]     = 1'b0;
      end
      if (act_q[i] && tick_d) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
        if (cnt_q[i] <= 8'd1) act_d[i] = 1'b0;
      end
      if (alarm_ack[i]) act_d[i] = 1'b0;
      if (tick_d && sec_d == 6'd0 && al_en_q[i]
          && al_hour_q[i] == hour_d && al_min_q[i] == min_d) begin
        hit_d[i] = 1'b1;
        act_d[i] = 1'b1;
        cnt_d[i] = 8'(ALARM_SECS);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 14'(RST_YEAR);
      week_q  <= 3'd1;
      tick_q  <= 1'b0;
      chime_q <= 1'b0;
      err_q   <= 1'b0;
      al_en_q <= '0;
      act_q   <= '0;
      hit_q   <= '0;
      for (int i = 0; i < ALARM_NUM; i++) begin
        al_hour_q[i] <= 5'd23;
        al_min_q[i]  <= 6'd59;
        cnt_q[i]     <= '0;
      end
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      week_q  <= week_d;
      tick_q  <= tick_d;
      chime_q <= chime_d;
      err_q   <= err_d;
      al_en_q <= al_en_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      for (int i = 0; i < ALARM_NUM; i++) begin
        al_hour_q[i] <= al_hour_d[i];
        al_min_q[i]  <= al_min_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
    end
  end

  assign sec          = sec_q;
  assign min          = min_q;
  assign hour         = hour_q;
  assign day          = day_q;
  assign month        = month_q;
  assign year         = year_q;
  assign week         = week_q;
  assign sec_tick     = tick_q;
  assign chime        = chime_q;
  assign set_err      = err_q;
  assign alarm_hit    = hit_q;
  assign alarm_active = act_q;

endmodule

// File: doc/rtc_calendar_core.md
# rtc_calendar_core

Parametrised real-time calendar and alarm core: a prescaled seconds counter that cascades through minutes, hours, day, month and year, with day-of-week tracking and Gregorian leap-year handling. It provides a field-addressed set/step port for the key-driven adjust logic and ALARM_NUM independent hour:minute alarms with timed, acknowledgeable active flags. It sits between the board clock and the LCD/LED/beeper presentation blocks, which consume its registered binary outputs.

## Interface
- CLK_HZ, 50_000_000, clk cycles per second; minimum 2
- ALARM_NUM, 2, number of alarms; 1..8
- ALARM_SECS, 60, seconds an alarm stays active without ack; 1..255
- RST_YEAR, 2019, year loaded at reset; 0..9999
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- run  in  1  1 = timekeeping advances; 0 = frozen, prescaler held at 0
- set_valid  in  1  one-cycle write of set_data into field set_field
- step_up / step_down  in  1  one-cycle increment/decrement of field set_field, with wrap
- set_field  in  3  0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 week; 7 is illegal
- set_data  in  14  binary value for set_valid
- set_err  out  1  one-cycle pulse: write rejected (illegal field or out-of-range value)
- alarm_wr  in  1  one-cycle write of alarm alarm_idx
- alarm_idx  in  3  alarm index; values >= ALARM_NUM are ignored
- alarm_hour  in  5, alarm_min  in  6, alarm_en_in  in  1  alarm write data
- alarm_ack  in  ALARM_NUM  per-alarm acknowledge
- sec, min  out  6 each; hour  out  5; day  out  5; month  out  4; year  out  14; week  out  3 (0 = Mon .. 6 = Sun)
- sec_tick  out  1  one-cycle pulse on every second advance
- chime  out  1  one-cycle pulse when advance lands on mm:ss = 00:00
- alarm_hit  out  ALARM_NUM  one-cycle pulse per matching alarm
- alarm_active  out  ALARM_NUM  level, alarm ringing

## Operation
- Reset: time 00:00:00, date RST_YEAR-01-01, week 1, prescaler 0, every alarm 23:59 disabled, all pulses and alarm_active 0.
- Prescaler counts 0..CLK_HZ-1 while run=1; on the cycle it equals CLK_HZ-1 it returns to 0 and an advance occurs.
- Advance: sec+1; 59 wraps to 0 and carries to min; min 59 -> hour; hour 23 -> day and week (6 wraps to 0); day == days_in_month -> day 1, month+1; month 12 -> 1, year+1; year 9999 -> 0. The whole cascade resolves in one cycle.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if (year%4==0 and year%100!=0) or year%400==0, else 28.
- Set: legal ranges sec/min 0..59, hour 0..23, day 1..days_in_month, month 1..12, year 0..9999, week 0..6. An illegal field or value leaves state unchanged and pulses set_err.
- Step: the field wraps within its legal range (step_up at max -> min, step_down at min -> max); year wraps between 9999 and 0. Field 7 pulses set_err.
- After any accepted month or year change, day is clamped to the new days_in_month (e.g. 2020-03-31 set month=2 gives 2020-02-29).
- Any accepted set or step clears the prescaler to 0.
- Priority in one cycle: set_valid > step_up > step_down > advance. An advance coinciding with an accepted set or step is dropped.
- Alarm i matches when an advance produces sec=0 with hour/min equal to alarm i and alarm i is enabled. A match pulses alarm_hit[i], sets alarm_active[i] and loads its down-counter with ALARM_SECS.
- While active, each sec_tick decrements the counter. Reaching 0 clears alarm_active[i]. alarm_ack[i] clears it immediately. A hit and an ack in the same cycle leave the alarm active.
- alarm_wr to an active alarm clears alarm_active for that index.

## Timing
- Every output is registered. Field values, sec_tick, chime and alarm_hit all update on the same clk edge as the advance.
- An accepted set or step is visible on the outputs on the next edge. set_err rises on the edge after set_valid, step_up or step_down.
- run deasserted mid-second discards the partial count. After run rises, the first advance comes CLK_HZ cycles later.
- rst has priority over every input. Asserting it mid-cascade or mid-alarm restores all reset values on the next edge.

## Test plan
- CLK_HZ=4: set 23:59:59 on 2019-12-31 with week 6, run 4 cycles -> 00:00:00 2020-01-01, week 0, sec_tick and chime each pulse once.
- Leap-year checks. Set 2100-02-28 23:59:59 and advance -> 2100-03-01. Repeat for 2000 -> 2000-02-29. Repeat for 2024 -> 2024-02-29.
- Write checks. set_field=2 with data 24 -> set_err, hour unchanged. 2021-01-31 then set month=2 -> day 28. step_down on min=0 -> 59. step_up on year 9999 -> 0.
- Alarm 1 at 07:30 enabled, time 07:29:59 -> after one advance alarm_hit=2'b10 for one cycle. alarm_active[1] stays high ALARM_SECS=3 ticks, then clears.
- Ack checks. Ack during active -> clear next edge. Ack coincident with hit -> stays active. Disabled alarm with same time -> no hit.
- Priority checks. set_valid on the advance cycle -> advance dropped, prescaler 0. rst asserted mid-alarm -> all outputs at reset values next edge.
